// File: rtl/bp_l15_pkg.sv
// Shared field widths, opcodes and packed packet layouts for the L1.5 fill encoder.
package bp_l15_pkg;
  localparam int ADDR_W = 40;
  localparam int WAY_W  = 3;
  localparam int IDX_W  = 6;
  localparam int TAG_W  = 28;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 128;
  localparam int OPC_W  = 2;
  localparam int COH_W  = 3;
  localparam int RET_W  = 4;

  localparam logic [RET_W-1:0] LOAD_RET         = 4'b0000;
  localparam logic [OPC_W-1:0] DATA_WRITE       = 2'd1;
  localparam logic [OPC_W-1:0] TAG_SET          = 2'd2;
  localparam logic [OPC_W-1:0] STAT_CLEAR_DIRTY = 2'd1;
  localparam logic [COH_W-1:0] COH_E            = 3'd2;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} fill_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [WAY_W-1:0]  way;
    logic [LINE_W-1:0] data;
    logic [OPC_W-1:0]  opcode;
  } data_mem_pkt_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [WAY_W-1:0] way;
    logic [TAG_W-1:0] tag;
    logic [COH_W-1:0] state;
    logic [OPC_W-1:0] opcode;
  } tag_mem_pkt_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [WAY_W-1:0] way;
    logic [OPC_W-1:0] opcode;
  } stat_mem_pkt_t;
endpackage

// File: rtl/bp_l15_line_buffer.sv
// Beat-indexed line register: each 128-bit beat lands in its own slice of the 512-bit line.
module bp_l15_line_buffer
  import bp_l15_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [1:0]        beat_i,
  input  logic [BEAT_W-1:0] data_i,
  output logic [LINE_W-1:0] line_o
);
  logic [BEATS-1:0][BEAT_W-1:0] beat_q;

  // Contents only matter once all beats are written, so no reset.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    always_ff @(posedge clk_i) begin
      if (we_i && beat_i == 2'(b)) beat_q[b] <= data_i;
    end
  end

  assign line_o = beat_q;
endmodule

// File: rtl/bp_l15_fill_encoder.sv
// Collects L1.5 load-return beats into a line and emits data/tag/stat write packets.
module bp_l15_fill_encoder
  import bp_l15_pkg::*;
#(
  parameter logic [RET_W-1:0] LOAD_RET = bp_l15_pkg::LOAD_RET,
  parameter int               BEATS    = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              fill_v_i,
  output logic              fill_ready_o,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [WAY_W-1:0]  fill_way_i,
  input  logic              l15_transducer_val,
  input  logic [RET_W-1:0]  l15_transducer_returntype,
  input  logic [63:0]       l15_transducer_data_0,
  input  logic [63:0]       l15_transducer_data_1,
  output logic              transducer_l15_req_ack,
  output data_mem_pkt_t     data_mem_pkt_o,
  output logic              data_mem_pkt_v_o,
  input  logic              data_mem_pkt_yumi_i,
  output tag_mem_pkt_t      tag_mem_pkt_o,
  output logic              tag_mem_pkt_v_o,
  input  logic              tag_mem_pkt_yumi_i,
  output stat_mem_pkt_t     stat_mem_pkt_o,
  output logic              stat_mem_pkt_v_o,
  input  logic              stat_mem_pkt_yumi_i,
  output logic              fill_done_o
);
  fill_state_e       state_q, state_d;
  logic [IDX_W-1:0]  index_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WAY_W-1:0]  way_q;
  logic [1:0]        beat_q;
  logic              data_v_q, tag_v_q, stat_v_q, fill_done_q;
  logic              data_v_nx, tag_v_nx, stat_v_nx;
  logic              is_load, capture, beat_acc, last_beat, send_done;
  logic [LINE_W-1:0] line;
  logic              unused_addr;

  assign unused_addr = ^fill_addr_i[5:0];

  assign is_load   = (l15_transducer_returntype == LOAD_RET);
  assign capture   = (state_q == IDLE) && fill_v_i;
  assign beat_acc  = (state_q == COLLECT) && l15_transducer_val && is_load;
  assign last_beat = beat_acc && (beat_q == 2'(BEATS-1));

  // Non-load returns are always swallowed; load returns only while collecting.
  assign transducer_l15_req_ack = reset_n_i && l15_transducer_val
                                  && (!is_load || state_q == COLLECT);

  assign data_v_nx = data_v_q & ~data_mem_pkt_yumi_i;
  assign tag_v_nx  = tag_v_q  & ~tag_mem_pkt_yumi_i;
  assign stat_v_nx = stat_v_q & ~stat_mem_pkt_yumi_i;
  assign send_done = (state_q == SEND) && !(data_v_nx || tag_v_nx || stat_v_nx);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_v_i)  state_d = COLLECT;
      COLLECT: if (last_beat) state_d = SEND;
      SEND:    if (send_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_q      <= '0;
      data_v_q    <= 1'b0;
      tag_v_q     <= 1'b0;
      stat_v_q    <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= send_done;
      if (capture)       beat_q <= '0;
      else if (beat_acc) beat_q <= beat_q + 2'd1;
      if (last_beat) begin
        data_v_q <= 1'b1;
        tag_v_q  <= 1'b1;
        stat_v_q <= 1'b1;
      end else if (state_q == SEND) begin
        data_v_q <= data_v_nx;
        tag_v_q  <= tag_v_nx;
        stat_v_q <= stat_v_nx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      index_q <= fill_addr_i[11:6];
      tag_q   <= fill_addr_i[39:12];
      way_q   <= fill_way_i;
    end
  end

  bp_l15_line_buffer #(.BEATS(BEATS)) u_line_buffer (
    .clk_i  (clk_i),
    .we_i   (beat_acc),
    .beat_i (beat_q),
    .data_i ({l15_transducer_data_1, l15_transducer_data_0}),
    .line_o (line)
  );

  assign data_mem_pkt_o = '{index: index_q, way: way_q, data: line, opcode: DATA_WRITE};
  assign tag_mem_pkt_o  = '{index: index_q, way: way_q, tag: tag_q, state: COH_E, opcode: TAG_SET};
  assign stat_mem_pkt_o = '{index: index_q, way: way_q, opcode: STAT_CLEAR_DIRTY};

  assign data_mem_pkt_v_o = data_v_q;
  assign tag_mem_pkt_v_o  = tag_v_q;
  assign stat_mem_pkt_v_o = stat_v_q;
  assign fill_done_o      = fill_done_q;
  assign fill_ready_o     = (state_q == IDLE);
endmodule

// File: doc/bp_l15_fill_encoder.md
BP_L15_FILL_ENCODER -- requirements
Module: bp_l15_fill_encoder

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port fill_v_i / fill_ready_o, input / output, 1 / 1: miss-context valid/ready handshake.
REQ-004 SHALL have port fill_addr_i, input, 40: miss physical address.
REQ-005 SHALL have port fill_way_i, input, 3: victim (LRU) way.
REQ-006 SHALL have port l15_transducer_val, input, 1: L1.5 return valid.
REQ-007 SHALL have port l15_transducer_returntype, input, 4: return type.
REQ-008 SHALL have ports l15_transducer_data_0 / l15_transducer_data_1, input, 64 each: return beat, data_0 lower half.
REQ-009 SHALL have port transducer_l15_req_ack, output, 1: return consumed this cycle.
REQ-010 SHALL have ports data_mem_pkt_o (523) / data_mem_pkt_v_o (1), outputs, with data_mem_pkt_yumi_i (1) input.
REQ-011 SHALL have ports tag_mem_pkt_o (42) / tag_mem_pkt_v_o (1), outputs, with tag_mem_pkt_yumi_i (1) input.
REQ-012 SHALL have ports stat_mem_pkt_o (11) / stat_mem_pkt_v_o (1), outputs, with stat_mem_pkt_yumi_i (1) input.
REQ-013 SHALL have port fill_done_o, output, 1: one-cycle pulse when all three packets are consumed.
REQ-014 SHALL have parameter LOAD_RET, default 4'b0000: returntype carrying fill data.
REQ-015 SHALL have parameter BEATS, default 4: 128-bit beats per 512-bit line.

Function
REQ-016 SHALL implement states IDLE, COLLECT, SEND; fill_ready_o = (state==IDLE).
REQ-017 IDLE: fill_v_i=1 SHALL capture index=addr[11:6], tag=addr[39:12], way, clear beat counter, and enter COLLECT next cycle.
REQ-018 COLLECT: transducer_l15_req_ack SHALL equal l15_transducer_val combinationally; a LOAD_RET beat k SHALL write {data_1,data_0} into line bits [128k+127:128k].
REQ-019 Beat counter SHALL be 2 bits; acceptance of beat BEATS-1 SHALL move to SEND and assert all three pkt valids the next cycle.
REQ-020 Non-LOAD_RET returns SHALL be acked in any state and dropped, without touching buffer or counter.
REQ-021 LOAD_RET arriving in IDLE or SEND SHALL NOT be acked (held by L1.5).
REQ-022 SEND: each pkt valid SHALL stay high, payload stable, until its yumi; yumi while valid low SHALL be ignored.
REQ-023 Yumis MAY arrive in any order or simultaneously; the cycle the last outstanding valid drops, fill_done_o SHALL pulse and state SHALL return to IDLE.
REQ-024 data_mem_pkt_o SHALL be {index[5:0], way[2:0], line[511:0], opcode DATA_WRITE=2'd1}, MSB first.
REQ-025 tag_mem_pkt_o SHALL be {index, way, tag[27:0], state COH_E=3'd2, opcode TAG_SET=2'd2}.
REQ-026 stat_mem_pkt_o SHALL be {index, way, opcode STAT_CLEAR_DIRTY=2'd1}.
REQ-027 fill_v_i outside IDLE SHALL have no effect.

Reset
REQ-028 Asserting reset_n_i low SHALL, asynchronously and at any state (including mid-COLLECT or mid-SEND), force IDLE, counter 0, all pkt valids 0, fill_done_o 0, req_ack 0; buffer contents unspecified.
REQ-029 After deassertion, fill_ready_o SHALL be 1 on the first clock edge.

Structure
REQ-030 Opcode/state constants, LOAD_RET, field widths and the three packed packet structs SHALL live in shared package bp_l15_pkg.
REQ-031 One sub-module, bp_l15_line_buffer (512-bit beat-indexed register), is natural; the FSM stays in the top.

Verification
REQ-032 Fill addr 40'hAB_CDEF_0040, way 5; four LOAD_RET beats 0x0..0x3 patterns; all yumis next cycle -> index 6'h01, tag 28'hABCDEF0, way 5, line beat-ordered, fill_done_o one pulse.
REQ-033 Beats with val gaps, interleaved returntype 4'b0011 -> those acked and dropped, line identical to the gap-free case.
REQ-034 Yumis stat, data, tag on cycles +0,+3,+7 -> each valid drops individually, fill_done_o only at +7.
REQ-035 LOAD_RET offered in IDLE for 5 cycles -> req_ack 0 throughout; fill_v_i then -> ack from the first COLLECT cycle.
REQ-036 reset_n_i low after beat 2 -> all outputs cleared immediately; new fill completes correctly.
REQ-037 Simultaneous three yumis -> fill_done_o next edge, fill_ready_o 1.
